// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl: qualifies and registers KxK convolution windows from chained line buffers.
// Optional feature: define WINDOW_COUNT_EN to add the 16-bit window_count output.
module conv_window_ctrl #(
    parameter int KERNEL_SIZE = 3,
    parameter int DATA_SIZE   = 8,
    parameter int ROW_SIZE    = 5,
    parameter int COL_SIZE    = 5,
    parameter int STRIDE      = 1
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic                                      data_valid,
    input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_SIZE-1:0] window_in,
    output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_SIZE-1:0] window_out,
    output logic                                      window_valid,
`ifdef WINDOW_COUNT_EN
    output logic                                      frame_done,
    output logic [15:0]                               window_count
`else
    output logic                                      frame_done
`endif
);

    localparam int W  = KERNEL_SIZE * KERNEL_SIZE * DATA_SIZE;
    localparam int CW = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
    localparam int RW = (COL_SIZE > 1) ? $clog2(COL_SIZE) : 1;
    localparam int SW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [SW-1:0] r_col_ph;
    logic [SW-1:0] r_row_ph;

    logic          r_acc;
    logic          r_qual;
    logic          r_last;

    logic [W-1:0]  r_window_out;
    logic          r_window_valid;
    logic          r_frame_done;

    logic          w_col_last;
    logic          w_row_last;
    logic          w_col_ge;
    logic          w_row_ge;
    logic          w_qual;
    logic          w_frame_last;
    logic [SW-1:0] w_col_ph_step;
    logic [SW-1:0] w_row_ph_step;

    // Position decode: wrap points, kernel-fill thresholds, stride phase steps.
    always_comb begin
        w_col_last    = (r_col == CW'(ROW_SIZE - 1));
        w_row_last    = (r_row == RW'(COL_SIZE - 1));
        w_col_ge      = (32'(r_col) >= KERNEL_SIZE - 1);
        w_row_ge      = (32'(r_row) >= KERNEL_SIZE - 1);
        w_col_ph_step = (r_col_ph == SW'(STRIDE - 1)) ? '0 : r_col_ph + SW'(1);
        w_row_ph_step = (r_row_ph == SW'(STRIDE - 1)) ? '0 : r_row_ph + SW'(1);
        w_qual        = w_col_ge && w_row_ge
                        && (r_col_ph == '0) && (r_row_ph == '0);
        w_frame_last  = w_col_last && w_row_last;
    end

    // Raster counters and stride phases; phases only run once the kernel has filled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_col    <= '0;
            r_row    <= '0;
            r_col_ph <= '0;
            r_row_ph <= '0;
        end else if (data_valid) begin
            if (w_col_last) begin
                r_col    <= '0;
                r_col_ph <= '0;
                if (w_row_last) begin
                    r_row    <= '0;
                    r_row_ph <= '0;
                end else begin
                    r_row    <= r_row + RW'(1);
                    r_row_ph <= w_row_ge ? w_row_ph_step : '0;
                end
            end else begin
                r_col    <= r_col + CW'(1);
                r_col_ph <= w_col_ge ? w_col_ph_step : '0;
            end
        end
    end

    // Stage 1: accept strobe every cycle; pixel qualifiers hold through gaps.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_acc  <= 1'b0;
            r_qual <= 1'b0;
            r_last <= 1'b0;
        end else begin
            r_acc <= data_valid;
            if (data_valid) begin
                r_qual <= w_qual;
                r_last <= w_frame_last;
            end
        end
    end

    // Stage 2: sample the line-buffer window one cycle after each accept.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_window_out   <= '0;
            r_window_valid <= 1'b0;
            r_frame_done   <= 1'b0;
        end else begin
            if (r_acc) begin
                r_window_out <= window_in;
            end
            r_window_valid <= r_acc && r_qual;
            r_frame_done   <= r_acc && r_last;
        end
    end

`ifdef WINDOW_COUNT_EN
    logic [15:0] r_window_count;

    // Windows emitted this frame; restarts the cycle after frame_done.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_window_count <= '0;
        end else if (r_frame_done) begin
            r_window_count <= (r_acc && r_qual) ? 16'd1 : 16'd0;
        end else if (r_acc && r_qual) begin
            r_window_count <= r_window_count + 16'd1;
        end
    end

    assign window_count = r_window_count;
`endif

    assign window_out   = r_window_out;
    assign window_valid = r_window_valid;
    assign frame_done   = r_frame_done;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// tb_conv_window_ctrl: table-driven and randomized-gap checks of conv_window_ctrl
// at STRIDE 1 and STRIDE 2 against a raster-position reference model.
module tb_conv_window_ctrl;

    localparam int K    = 3;
    localparam int DS   = 8;
    localparam int RS   = 5;
    localparam int CS   = 5;
    localparam int W    = K * K * DS;
    localparam int NPIX = RS * CS;

    logic         clock = 1'b0;
    logic         reset;
    logic         data_valid;
    logic [W-1:0] window_in;
    logic [W-1:0] wo_a, wo_b;
    logic         wv_a, wv_b, fd_a, fd_b;
`ifdef WINDOW_COUNT_EN
    logic [15:0]  wc_a, wc_b;
`endif

    always #5 clock = ~clock;

    conv_window_ctrl #(
        .KERNEL_SIZE(K), .DATA_SIZE(DS), .ROW_SIZE(RS), .COL_SIZE(CS), .STRIDE(1)
    ) u_dut_s1 (
        .clock(clock), .reset(reset), .data_valid(data_valid),
        .window_in(window_in), .window_out(wo_a),
        .window_valid(wv_a),
`ifdef WINDOW_COUNT_EN
        .frame_done(fd_a), .window_count(wc_a)
`else
        .frame_done(fd_a)
`endif
    );

    conv_window_ctrl #(
        .KERNEL_SIZE(K), .DATA_SIZE(DS), .ROW_SIZE(RS), .COL_SIZE(CS), .STRIDE(2)
    ) u_dut_s2 (
        .clock(clock), .reset(reset), .data_valid(data_valid),
        .window_in(window_in), .window_out(wo_b),
        .window_valid(wv_b),
`ifdef WINDOW_COUNT_EN
        .frame_done(fd_b), .window_count(wc_b)
`else
        .frame_done(fd_b)
`endif
    );

    int checks = 0;
    int errors = 0;

    int           cyc;
    int           idx;
    bit           prev_acc;
    logic [W-1:0] prev_win;
    bit           sch_a[int];
    bit           sch_b[int];
    bit           sch_fd[int];
    logic [W-1:0] sch_win[int];
    logic [W-1:0] exp_wo;
    int           exp_cnt_a, exp_cnt_b;
    bit           prev_fd_exp;

    int           n_wa, n_wb, first_wa, e0;
    logic [W-1:0] first_win;
    int           fd_cyc[$];

    typedef struct {
        int npix;
        int gap;
        int exp_wa;
        int exp_wb;
        int exp_fd;
        int exp_first;
    } vec_t;

    function automatic logic [W-1:0] win_of(int r, int c);
        logic [W-1:0] w;
        w = '0;
        for (int kr = 0; kr < K; kr++) begin
            for (int kc = 0; kc < K; kc++) begin
                int pr, pc, v;
                pr = r - (K - 1) + kr;
                pc = c - (K - 1) + kc;
                v  = (pr >= 0 && pc >= 0) ? pr * RS + pc + 1 : 0;
                w[(kr*K+kc)*DS +: DS] = 8'(v);
            end
        end
        return w;
    endfunction

    function automatic bit qual(int r, int c, int s);
        return r >= K - 1 && c >= K - 1
            && (r - (K - 1)) % s == 0 && (c - (K - 1)) % s == 0;
    endfunction

    function automatic logic [W-1:0] rand_win();
        logic [W-1:0] w;
        for (int j = 0; j < K * K; j++) w[j*DS +: DS] = 8'($urandom);
        return w;
    endfunction

    task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic chk_i(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic clear_model();
        sch_a.delete();
        sch_b.delete();
        sch_fd.delete();
        sch_win.delete();
        idx         = 0;
        prev_acc    = 0;
        prev_win    = '0;
        exp_wo      = '0;
        exp_cnt_a   = 0;
        exp_cnt_b   = 0;
        prev_fd_exp = 0;
    endtask

    task automatic reset_stats();
        n_wa      = 0;
        n_wb      = 0;
        first_wa  = -1;
        e0        = -1;
        first_win = '0;
        fd_cyc.delete();
    endtask

    task automatic check_outputs();
        bit ea, eb, efd;
        ea  = sch_a.exists(cyc)  ? sch_a[cyc]  : 1'b0;
        eb  = sch_b.exists(cyc)  ? sch_b[cyc]  : 1'b0;
        efd = sch_fd.exists(cyc) ? sch_fd[cyc] : 1'b0;
        if (sch_win.exists(cyc)) exp_wo = sch_win[cyc];
        if (prev_fd_exp) begin
            exp_cnt_a = 0;
            exp_cnt_b = 0;
        end
        exp_cnt_a  += int'(ea);
        exp_cnt_b  += int'(eb);
        prev_fd_exp = efd;
        chk("wv_s1", W'(wv_a), W'(ea));
        chk("wv_s2", W'(wv_b), W'(eb));
        chk("fd_s1", W'(fd_a), W'(efd));
        chk("fd_s2", W'(fd_b), W'(efd));
        chk("wo_s1", wo_a, exp_wo);
        chk("wo_s2", wo_b, exp_wo);
`ifdef WINDOW_COUNT_EN
        chk("wc_s1", W'(wc_a), W'(exp_cnt_a));
        chk("wc_s2", W'(wc_b), W'(exp_cnt_b));
`endif
        if (wv_a) begin
            n_wa++;
            if (first_wa < 0) begin
                first_wa  = cyc - e0;
                first_win = wo_a;
            end
        end
        if (wv_b) n_wb++;
        if (fd_a) fd_cyc.push_back(cyc - e0);
        sch_a.delete(cyc);
        sch_b.delete(cyc);
        sch_fd.delete(cyc);
        sch_win.delete(cyc);
    endtask

    task automatic tick(bit dv);
        int r, c;
        data_valid = dv;
        window_in  = prev_acc ? prev_win : rand_win();
        prev_acc   = dv && !reset;
        if (dv && !reset) begin
            r = idx / RS;
            c = idx % RS;
            sch_a[cyc+1]   = qual(r, c, 1);
            sch_b[cyc+1]   = qual(r, c, 2);
            sch_fd[cyc+1]  = (idx == NPIX - 1);
            sch_win[cyc+1] = win_of(r, c);
            prev_win       = win_of(r, c);
            if (e0 < 0) e0 = cyc;
            idx = (idx + 1) % NPIX;
        end
        @(posedge clock);
        @(negedge clock);
        check_outputs();
        cyc++;
    endtask

    task automatic do_reset(int n);
        reset      = 1'b1;
        data_valid = 1'b0;
        clear_model();
        #1;
        check_outputs();
        repeat (n) tick(1'b0);
        reset = 1'b0;
    endtask

    task automatic run(int npix, int gap);
        for (int i = 0; i < npix; i++) begin
            tick(1'b1);
            if (gap == 1) tick(1'b0);
            else if (gap == 2) repeat ($urandom_range(0, 3)) tick(1'b0);
        end
        repeat (3) tick(1'b0);
    endtask

    initial begin
        vec_t         vecs[5];
        logic [W-1:0] k13;

        vecs[0] = '{npix: 25, gap: 0, exp_wa: 9,  exp_wb: 4,  exp_fd: 1, exp_first: 13};
        vecs[1] = '{npix: 25, gap: 1, exp_wa: 9,  exp_wb: 4,  exp_fd: 1, exp_first: 25};
        vecs[2] = '{npix: 50, gap: 0, exp_wa: 18, exp_wb: 8,  exp_fd: 2, exp_first: 13};
        vecs[3] = '{npix: 25, gap: 2, exp_wa: 9,  exp_wb: 4,  exp_fd: 1, exp_first: -1};
        vecs[4] = '{npix: 75, gap: 2, exp_wa: 27, exp_wb: 12, exp_fd: 3, exp_first: -1};
        k13 = {8'd13, 8'd12, 8'd11, 8'd8, 8'd7, 8'd6, 8'd3, 8'd2, 8'd1};

        reset      = 1'b0;
        data_valid = 1'b0;
        window_in  = '0;
        cyc        = 0;
        clear_model();
        reset_stats();
        #2 reset = 1'b1;
        @(negedge clock);
        check_outputs();
        do_reset(2);

        for (int v = 0; v < 5; v++) begin
            do_reset(2);
            reset_stats();
            run(vecs[v].npix, vecs[v].gap);
            chk_i($sformatf("vec%0d_windows_s1", v), n_wa, vecs[v].exp_wa);
            chk_i($sformatf("vec%0d_windows_s2", v), n_wb, vecs[v].exp_wb);
            chk_i($sformatf("vec%0d_frame_done", v), fd_cyc.size(), vecs[v].exp_fd);
            if (vecs[v].exp_first >= 0)
                chk_i($sformatf("vec%0d_first_window", v), first_wa, vecs[v].exp_first);
        end

        do_reset(2);
        reset_stats();
        run(25, 0);
        chk("first_window_contents", first_win, k13);

        do_reset(2);
        reset_stats();
        run(50, 0);
        chk_i("two_frames_done_count", fd_cyc.size(), 2);
        if (fd_cyc.size() == 2) begin
            chk_i("frame1_done_cycle", fd_cyc[0] + 2, 27);
            chk_i("frame2_done_cycle", fd_cyc[1] + 2, 52);
        end

        do_reset(2);
        reset_stats();
        repeat (8) tick(1'b1);
        do_reset(3);
        reset_stats();
        run(25, 0);
        chk_i("post_reset_windows", n_wa, 9);
        chk_i("post_reset_first_window", first_wa, 13);
        chk("post_reset_first_contents", first_win, k13);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_window_ctrl.md
CONV_WINDOW_CTRL -- requirements
Module: conv_window_ctrl

Interface
REQ-001 SHALL have parameter KERNEL_SIZE, default 3: window edge length K, in pixels.
REQ-002 SHALL have parameter DATA_SIZE, default 8: bits per pixel.
REQ-003 SHALL have parameter ROW_SIZE, default 5: image width in pixels, equal to the line-buffer row length.
REQ-004 SHALL have parameter COL_SIZE, default 5: image height in rows.
REQ-005 SHALL have parameter STRIDE, default 1: window step in both directions; legal range is 1 or greater.
REQ-006 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port data_valid, input, 1 bit: the same strobe that drives the upstream line buffers; each high cycle is one accepted pixel.
REQ-009 SHALL have port window_in, input, K*K*DATA_SIZE bits: the concatenated kernel_row_out buses of the K chained line buffers. Row r occupies bits [(r+1)*K*DATA_SIZE-1 : r*K*DATA_SIZE].
REQ-010 SHALL have port window_out, output, K*K*DATA_SIZE bits: the registered window, in the same bit layout as window_in.
REQ-011 SHALL have port window_valid, output, 1 bit: one-cycle strobe marking window_out as a legal convolution window.
REQ-012 SHALL have port frame_done, output, 1 bit: one-cycle strobe marking the last pixel of the frame.

Function
REQ-013 SHALL hold column counter col (0..ROW_SIZE-1) and row counter row (0..COL_SIZE-1); both advance only on data_valid=1 cycles.
REQ-014 On data_valid=1, col SHALL increment. At col=ROW_SIZE-1 it SHALL wrap to 0 and row SHALL increment.
REQ-015 At row=COL_SIZE-1 and col=ROW_SIZE-1, both counters SHALL wrap to 0, so the next frame starts with no idle cycle.
REQ-016 When data_valid=0, counters and all stage-1 state SHALL hold. Gaps of any length SHALL be tolerated.
REQ-017 Stage 1: on each data_valid=1 cycle, the block SHALL register an accept flag and the (row, col, last) qualifiers of the accepted pixel.
REQ-018 Stage 2: on the cycle after an accept, the block SHALL sample window_in into window_out. This absorbs the one-cycle register delay of the upstream line buffers.
REQ-019 window_valid SHALL be 1 exactly 2 cycles after the data_valid cycle of a qualifying pixel, and 0 otherwise.
REQ-020 A pixel qualifies when all of the following hold: row >= K-1, col >= K-1, (row-(K-1)) mod STRIDE = 0, and (col-(K-1)) mod STRIDE = 0.
REQ-021 The stride qualification SHALL use phase counters that reset with col and row. No divider or modulo operator SHALL be used.
REQ-022 window_out SHALL load on every accepted pixel, qualified or not, and SHALL hold between accepts.
REQ-023 frame_done SHALL pulse 2 cycles after the data_valid cycle of pixel (COL_SIZE-1, ROW_SIZE-1), independent of window_valid.
REQ-024 If the last pixel also qualifies, frame_done and window_valid SHALL both be 1 on the same cycle.
REQ-025 Back-to-back data_valid SHALL yield back-to-back window_valid. The block SHALL apply no backpressure.

Reset
REQ-026 Asserting reset SHALL immediately force: col=0, row=0, stride phases=0, accept flags=0, window_out=0, window_valid=0, frame_done=0.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame. The first data_valid after release SHALL be treated as pixel (0,0).

Configuration
REQ-028 When macro WINDOW_COUNT_EN is defined, the block SHALL add output window_count, 16 bits.
REQ-029 With WINDOW_COUNT_EN, window_count SHALL increment on every window_valid cycle and SHALL clear to 0 on the cycle after frame_done. Reset value SHALL be 0.
REQ-030 Without WINDOW_COUNT_EN, port window_count and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-031 Defaults, 25 consecutive data_valid cycles (pixel values 1..25): window_valid SHALL be 1 nine times. The first pulse SHALL occur 2 cycles after the 13th pixel, with window_out holding the 3x3 window whose bottom-right is pixel 13.
REQ-032 STRIDE=2, one 5x5 frame: exactly 4 window_valid pulses, for bottom-right pixels at (row, col) = (2,2), (2,4), (4,2), (4,4).
REQ-033 Defaults, data_valid alternating 1/0 for one frame: the same 9 windows and contents as REQ-031. Each pulse SHALL trail its qualifying pixel by 2 cycles.
REQ-034 Defaults, two back-to-back frames: frame_done SHALL pulse on cycles 27 and 52, coincident with window_valid. The second frame's first window SHALL match REQ-031's timing relative to its own start.
REQ-035 Reset pulsed after pixel 8, then a fresh 25-pixel frame: outputs SHALL read 0 during reset, and exactly 9 windows SHALL follow with REQ-031 timing.
REQ-036 With WINDOW_COUNT_EN, defaults, one frame: window_count SHALL reach 9 on the frame_done cycle and read 0 on the following cycle.
